// File: rtl/wb_cond_commit.sv
// Writeback commit stage: gates register writes by op class and condition code,
// owns the architectural flags, and presents a one-entry valid/ready output register.
module wb_cond_commit #(
    parameter int                      FLAG_W    = 2,
    parameter int                      OPC_W     = 4,
    parameter logic [(2**OPC_W)-1:0]   COND_MASK = 16'h0005,
    parameter logic [(2**OPC_W)-1:0]   UNC_MASK  = 16'h0012,
    parameter int                      DATA_W    = 16,
    parameter int                      REG_AW    = 3,
    parameter int                      FLAG_SRC  = 0,
    parameter int                      CNT_W     = 16,
    localparam int                     COND_W    = $clog2(FLAG_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic [OPC_W-1:0]  in_aluop,
    input  logic [COND_W-1:0] in_cond,
    input  logic [FLAG_W-1:0] in_prev_flags,
    input  logic              in_flag_we,
    input  logic [FLAG_W-1:0] in_flags_new,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic [REG_AW-1:0] out_dest,
    output logic [DATA_W-1:0] out_data,
    output logic              out_squashed,
    output logic [FLAG_W-1:0] flags_o,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    logic              valid_q;
    logic              regwrite_q;
    logic              squashed_q;
    logic [REG_AW-1:0] dest_q;
    logic [DATA_W-1:0] data_q;
    logic [FLAG_W-1:0] flags_q;
    logic [CNT_W-1:0]  commit_q;
    logic [CNT_W-1:0]  squash_q;

    logic [FLAG_W-1:0] flag_src;
    logic              accept;
    logic              pass;
    logic              we;
    logic              squashed;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign flag_src = (FLAG_SRC != 0) ? flags_q : in_prev_flags;

    // Conditions beyond the implemented flags never pass.
    always_comb begin
        pass = 1'b0;
        if (in_cond == '0) begin
            pass = 1'b1;
        end else begin
            for (int k = 0; k < FLAG_W; k++) begin
                if (int'(in_cond) == k + 1) begin
                    pass = flag_src[k];
                end
            end
        end
    end

    always_comb begin
        we       = 1'b0;
        squashed = 1'b0;
        if (COND_MASK[in_aluop]) begin
            we       = in_regwrite && pass;
            squashed = in_regwrite && !pass;
        end else if (UNC_MASK[in_aluop]) begin
            we       = in_regwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            squashed_q <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
            flags_q    <= '0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            regwrite_q <= we;
            squashed_q <= squashed;
            dest_q     <= in_dest;
            data_q     <= in_data;
            if (in_flag_we && !squashed) begin
                flags_q <= in_flags_new;
            end
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Clear outranks a same-cycle increment; both saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n || cnt_clr) begin
            commit_q <= '0;
            squash_q <= '0;
        end else if (accept) begin
            if (we && commit_q != '1) begin
                commit_q <= commit_q + CNT_W'(1);
            end
            if (squashed && squash_q != '1) begin
                squash_q <= squash_q + CNT_W'(1);
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_regwrite = valid_q && regwrite_q;
    assign out_squashed = valid_q && squashed_q;
    assign out_dest     = dest_q;
    assign out_data     = data_q;
    assign flags_o      = flags_q;
    assign commit_cnt   = commit_q;
    assign squash_cnt   = squash_q;

endmodule
